// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types for the I2C transaction arbiter
package i2c_pkg;

    localparam int I2C_AW = 7;
    localparam int I2C_DW = 8;

    typedef enum logic {
        ARB_DUMMY,
        ARB_OWNED
    } arb_state_t;

    typedef struct packed {
        logic              wr;
        logic [I2C_AW-1:0] addr;
        logic [I2C_DW-1:0] data;
    } i2c_txn_t;

    // Read of address 0: what the target runs while nobody owns it
    localparam i2c_txn_t TXN_DUMMY = '0;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first unmasked request at or after ptr
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         mask,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 gnt_vld,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);

    logic [N-1:0]  cand;
    logic [IW-1:0] idx;

    // Walk offsets from the far end back toward ptr so the nearest candidate is kept last
    always_comb begin
        cand    = req & ~mask;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % N);
            if (cand[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin owner sequencing of a free-running I2C memory target
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int AW      = I2C_AW,
    parameter int DW      = I2C_DW,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_wr,
    input  logic [N_REQ*AW-1:0]      req_addr,
    input  logic [N_REQ*DW-1:0]      req_wdata,
    output logic [N_REQ-1:0]         ack,
    output logic [DW-1:0]            rdata,
    output logic                     err,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     m_wr,
    output logic [AW-1:0]            m_addr,
    output logic [DW-1:0]            m_din,
    input  logic [DW-1:0]            m_datard,
    input  logic                     m_done,
    output logic                     timeout_sts
);

    localparam int IW = $clog2(N_REQ);
    localparam int WW = $clog2(TIMEOUT);

    arb_state_t       state_q, state_d;
    i2c_txn_t         txn_q, txn_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             tsts_q, tsts_d;

    logic [N_REQ-1:0] mask;
    logic             gnt_vld;
    logic [IW-1:0]    gnt_idx;
    logic             wdog_fire;
    logic             boundary;

    assign wdog_fire = (wdog_q == WW'(TIMEOUT - 1));
    assign boundary  = m_done | wdog_fire;
    // The owner being acked sits out the decision at its own boundary
    assign mask      = (state_q == ARB_OWNED) ? (N_REQ'(1) << owner_q) : '0;

    rr_pick #(.N(N_REQ)) u_pick (
        .req     (req),
        .mask    (mask),
        .ptr     (rr_ptr_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d  = state_q;
        txn_d    = txn_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        wdog_d   = wdog_q + 1'b1;
        ack_d    = '0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tsts_d   = tsts_q;

        if (boundary) begin
            wdog_d = '0;
            if (!m_done) begin
                tsts_d = 1'b1;
            end
            if (state_q == ARB_OWNED) begin
                ack_d = mask;
                err_d = !m_done;
                if (m_done && !txn_q.wr) begin
                    rdata_d = m_datard;
                end
            end
            if (gnt_vld) begin
                state_d    = ARB_OWNED;
                owner_d    = gnt_idx;
                txn_d.wr   = req_wr[gnt_idx];
                txn_d.addr = req_addr[gnt_idx*AW +: AW];
                txn_d.data = req_wdata[gnt_idx*DW +: DW];
                rr_ptr_d   = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                state_d = ARB_DUMMY;
                txn_d   = TXN_DUMMY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_DUMMY;
            txn_q    <= TXN_DUMMY;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            wdog_q   <= '0;
            ack_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tsts_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            txn_q    <= txn_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            wdog_q   <= wdog_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tsts_q   <= tsts_d;
        end
    end

    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign err         = err_q;
    assign busy        = (state_q == ARB_OWNED);
    assign owner       = owner_q;
    assign m_wr        = txn_q.wr;
    assign m_addr      = txn_q.addr;
    assign m_din       = txn_q.data;
    assign timeout_sts = tsts_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb/tb_i2c_txn_arbiter.sv - directed and randomized checks of i2c_txn_arbiter against a behavioural model
module tb_i2c_txn_arbiter;

    localparam int N  = 4;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_wr = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic            err, busy;
    logic [1:0]      owner;
    logic            m_wr;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_din, m_datard;
    logic            m_done, timeout_sts;

    logic [N-1:0]    hold = '0;
    logic            stall = 1'b0;
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    i2c_txn_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .err(err), .busy(busy),
        .owner(owner), .m_wr(m_wr), .m_addr(m_addr), .m_din(m_din),
        .m_datard(m_datard), .m_done(m_done), .timeout_sts(timeout_sts)
    );

    // Free-running target: start phase, data phase, done after 3..6 cycles; stall freezes it
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            t_ph = 0, t_len = 4;
    logic          t_wr = 1'b0;
    logic [AW-1:0] t_addr = '0;
    logic [DW-1:0] t_din = '0;

    assign m_done   = !stall && (t_ph == t_len - 1);
    assign m_datard = mem[t_addr];

    always @(posedge clk) begin
        if (rst) begin
            t_ph  <= 0;
            t_len <= 4;
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
        end else if (!stall) begin
            if (t_ph == 0) begin
                t_wr   <= m_wr;
                t_addr <= m_addr;
            end
            if (t_ph == 1) t_din <= m_din;
            if (t_ph == t_len - 1) begin
                if (t_wr) mem[t_addr] <= t_din;
                t_ph  <= 0;
                t_len <= int'($urandom_range(3, 6));
            end else begin
                t_ph <= t_ph + 1;
            end
        end
    end

    int cyc = 0, last_done = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_done) last_done <= cyc + 1;
    end

    // Behavioural model: ownership changes only at transaction boundaries
    logic [N-1:0]  e_ack = '0;
    logic [DW-1:0] e_rdata = '0;
    logic          e_err = 1'b0, e_owned = 1'b0, e_tsts = 1'b0;
    int            e_owner = 0, e_ptr = 0, e_wdog = 0;
    logic          e_wr = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_din = '0;

    always @(posedge clk) begin : model
        logic         fire;
        logic [N-1:0] cand;
        int           win;
        if (rst) begin
            e_ack <= '0; e_rdata <= '0; e_err <= 1'b0; e_owned <= 1'b0; e_tsts <= 1'b0;
            e_owner <= 0; e_ptr <= 0; e_wdog <= 0; e_wr <= 1'b0; e_addr <= '0; e_din <= '0;
        end else begin
            fire = m_done || (e_wdog == TO - 1);
            cand = req;
            if (e_owned) cand[e_owner] = 1'b0;
            win = -1;
            for (int k = 0; k < N; k++)
                if (win < 0 && cand[(e_ptr + k) % N]) win = (e_ptr + k) % N;
            e_ack  <= '0;
            e_wdog <= fire ? 0 : e_wdog + 1;
            if (fire) begin
                if (!m_done) e_tsts <= 1'b1;
                if (e_owned) begin
                    e_ack[e_owner] <= 1'b1;
                    e_err <= !m_done;
                    if (m_done && !e_wr) e_rdata <= m_datard;
                end
                if (win >= 0) begin
                    e_owned <= 1'b1;
                    e_owner <= win;
                    e_ptr   <= (win + 1) % N;
                    e_wr    <= req_wr[win];
                    e_addr  <= req_addr[win*AW +: AW];
                    e_din   <= req_wdata[win*DW +: DW];
                end else begin
                    e_owned <= 1'b0;
                    e_wr    <= 1'b0;
                    e_addr  <= '0;
                    e_din   <= '0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int            idx;
        logic          e;
        logic [DW-1:0] d;
    } ack_t;
    ack_t acks_q[$];

    always @(negedge clk) begin
        chk("ack", 32'(ack), 32'(e_ack));
        chk("rdata", 32'(rdata), 32'(e_rdata));
        chk("busy", 32'(busy), 32'(e_owned));
        chk("timeout_sts", 32'(timeout_sts), 32'(e_tsts));
        chk("m_wr", 32'(m_wr), 32'(e_wr));
        chk("m_addr", 32'(m_addr), 32'(e_addr));
        chk("m_din", 32'(m_din), 32'(e_din));
        if (e_owned) chk("owner", 32'(owner), e_owner);
        if (e_ack != '0) chk("err", 32'(err), 32'(e_err));
        for (int i = 0; i < N; i++)
            if (ack[i]) acks_q.push_back('{i, err, rdata});
    end

    task automatic tick();
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (ack[i] && !hold[i]) req[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wr[i]            = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req[i]               = 1'b1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = '0;
        hold  = '0;
        stall = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        acks_q.delete();
    endtask

    task automatic wait_acks(input int n, input int budget);
        int k = 0;
        while (acks_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (acks_q.size() < n) chk("ack_wait", acks_q.size(), n);
    endtask

    task automatic wait_grant(input int idx, input int budget);
        int k = 0;
        while (!(busy && owner == idx) && k < budget) begin
            tick();
            k++;
        end
        if (!(busy && owner == idx)) chk("grant_wait", 32'(owner), idx);
    endtask

    int exp_order [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        // Idle: only dummy reads, no acks
        do_reset();
        repeat (30) tick();
        chk("t1_acks", acks_q.size(), 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_maddr", 32'(m_addr), 0);
        chk("t1_mwr", 32'(m_wr), 0);

        // Write then read-back of the same address by another requester
        do_reset();
        set_req(2, 1'b1, 7'h15, 8'hA5);
        wait_grant(2, 40);
        set_req(1, 1'b0, 7'h15, 8'h00);
        wait_acks(2, 60);
        if (acks_q.size() >= 2) begin
            chk("t2_first", acks_q[0].idx, 2);
            chk("t2_first_err", 32'(acks_q[0].e), 0);
            chk("t2_second", acks_q[1].idx, 1);
            chk("t2_rdata", 32'(acks_q[1].d), 32'hA5);
            chk("t2_second_err", 32'(acks_q[1].e), 0);
        end

        // Everyone requesting continuously: strict rotation
        do_reset();
        hold = '1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(7'h20 + i), '0);
        wait_acks(6, 120);
        for (int i = 0; i < 6 && i < acks_q.size(); i++) chk("t3_order", acks_q[i].idx, exp_order[i]);

        // Lone re-requester, then a competitor cuts in ahead of its next grant
        do_reset();
        hold = 4'b0100;
        set_req(2, 1'b0, 7'h33, '0);
        wait_acks(2, 60);
        set_req(0, 1'b1, 7'h01, 8'h3C);
        wait_acks(4, 80);
        if (acks_q.size() >= 4) begin
            chk("t4_a0", acks_q[0].idx, 2);
            chk("t4_a1", acks_q[1].idx, 2);
            chk("t4_a2", acks_q[2].idx, 0);
            chk("t4_a3", acks_q[3].idx, 2);
        end
        hold = '0;
        req  = '0;

        // Hung target: watchdog acks the owner with err
        do_reset();
        set_req(3, 1'b1, 7'h40, 8'h5C);
        wait_grant(3, 40);
        stall = 1'b1;
        wait_acks(1, 40);
        if (acks_q.size() >= 1) begin
            chk("t5_idx", acks_q[0].idx, 3);
            chk("t5_err", 32'(acks_q[0].e), 1);
            chk("t5_rdata", 32'(acks_q[0].d), 0);
            chk("t5_latency", cyc - last_done, 16);
            chk("t5_sts", 32'(timeout_sts), 1);
        end
        repeat (40) tick();
        stall = 1'b0;
        repeat (20) tick();
        chk("t5_no_extra_ack", acks_q.size(), 1);
        chk("t5_sts_sticky", 32'(timeout_sts), 1);

        // Reset while owned
        do_reset();
        set_req(1, 1'b0, 7'h05, '0);
        wait_grant(1, 40);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_ack", 32'(ack), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_owner", 32'(owner), 0);
        chk("t6_maddr", 32'(m_addr), 0);
        chk("t6_mwr", 32'(m_wr), 0);
        chk("t6_rdata", 32'(rdata), 0);
        chk("t6_sts", 32'(timeout_sts), 0);
        rst = 1'b0;
        req = '0;
        acks_q.delete();
        repeat (20) tick();
        chk("t6_no_ack", acks_q.size(), 0);

        // Randomized traffic with occasional target stalls
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (c % 400 == 200) stall = 1'b1;
            if (c % 400 == 236) stall = 1'b0;
            for (int i = 0; i < N; i++)
                if (!req[i] && !ack[i] && $urandom_range(0, 5) == 0)
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
        end
        stall = 1'b0;
        req   = '0;
        repeat (40) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
